// File: rtl/v_tx_arbiter_if.sv
// rtl/v_tx_arbiter_if.sv - byte stream from the TX arbiter to the UART transmitter
//
// tx_data   8  byte presented to the transmitter
// tx_valid  1  tx_data holds a byte to send
// tx_ready  1  transmitter accepts the byte this cycle
// master = arbiter side, slave = transmitter side.
interface v_tx_arbiter_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/v_tx_arbiter.sv
// rtl/v_tx_arbiter.sv - round-robin arbiter serialising producer chunks onto one UART TX stream
//
// CLK, RST_N         clock, asynchronous active-low reset
// src_should_update  per-producer request
// src_chunk_type     8-bit chunk type per producer
// src_chunk_size     payload byte count per producer (clamped to P = TEXT_BUFFER_BYTE_SIZE-1)
// src_chunk_bytes    P payload bytes per producer, byte 0 in the lowest bits
// src_done           one-cycle pulse to the producer whose chunk has been sent
// tx                 byte stream to the transmitter (master side)
// busy               high whenever a frame is in progress
// grant_id           producer of the current or most recent frame
// Frame on the wire: type, size, then size payload bytes.
module v_tx_arbiter #(
    parameter int NUM_SOURCES            = 4,
    parameter int GRANT_W                = 2,
    parameter int TEXT_BUFFER_BYTE_SIZE  = 33,
    parameter int TEXT_BUFFER_INDEX_SIZE = 8
) (
    input  logic                                             CLK,
    input  logic                                             RST_N,
    input  logic [NUM_SOURCES-1:0]                           src_should_update,
    input  logic [NUM_SOURCES*8-1:0]                         src_chunk_type,
    input  logic [NUM_SOURCES*TEXT_BUFFER_INDEX_SIZE-1:0]    src_chunk_size,
    input  logic [NUM_SOURCES*(TEXT_BUFFER_BYTE_SIZE-1)*8-1:0] src_chunk_bytes,
    output logic [NUM_SOURCES-1:0]                           src_done,
    v_tx_arbiter_if.master                                   tx,
    output logic                                             busy,
    output logic [GRANT_W-1:0]                               grant_id
);
    localparam int P   = TEXT_BUFFER_BYTE_SIZE - 1;
    localparam int PW  = P * 8;
    localparam int ISZ = TEXT_BUFFER_INDEX_SIZE;

    localparam logic [2:0] IDLE         = 3'd0;
    localparam logic [2:0] SEND_TYPE    = 3'd1;
    localparam logic [2:0] SEND_SIZE    = 3'd2;
    localparam logic [2:0] SEND_PAYLOAD = 3'd3;
    localparam logic [2:0] ACK          = 3'd4;

    logic [2:0]             state_q, state_d;
    logic [GRANT_W-1:0]     last_q, last_d;
    logic [GRANT_W-1:0]     grant_q, grant_d;
    logic [7:0]             type_q, type_d;
    logic [7:0]             size_q, size_d;
    logic [PW-1:0]          bytes_q, bytes_d;
    logic [7:0]             cnt_q, cnt_d;
    logic                   tx_valid_q, tx_valid_d;
    logic [7:0]             tx_data_q, tx_data_d;
    logic [NUM_SOURCES-1:0] done_q, done_d;

    logic [GRANT_W-1:0] sel;
    logic [GRANT_W-1:0] cand;
    logic               found;
    logic [7:0]         size_ext;
    logic [7:0]         size_clamped;
    logic [7:0]         nxt_cnt;
    logic               hs;

    // Scan starts just after the previous winner, so the last winner has lowest priority.
    always_comb begin
        sel   = last_q;
        cand  = '0;
        found = 1'b0;
        for (int i = 1; i <= NUM_SOURCES; i++) begin
            cand = GRANT_W'((int'(last_q) + i) % NUM_SOURCES);
            if (!found && src_should_update[cand]) begin
                sel   = cand;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        size_ext     = 8'(src_chunk_size[int'(sel)*ISZ +: ISZ]);
        size_clamped = (size_ext > 8'(P)) ? 8'(P) : size_ext;
    end

    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        grant_d    = grant_q;
        type_d     = type_q;
        size_d     = size_q;
        bytes_d    = bytes_q;
        cnt_d      = cnt_q;
        tx_valid_d = tx_valid_q;
        tx_data_d  = tx_data_q;
        done_d     = '0;
        nxt_cnt    = cnt_q + 8'd1;
        hs         = tx_valid_q && tx.tx_ready;
        case (state_q)
            IDLE: begin
                if (|src_should_update) begin
                    state_d    = SEND_TYPE;
                    last_d     = sel;
                    grant_d    = sel;
                    type_d     = src_chunk_type[int'(sel)*8 +: 8];
                    size_d     = size_clamped;
                    bytes_d    = src_chunk_bytes[int'(sel)*PW +: PW];
                    cnt_d      = 8'd0;
                    tx_valid_d = 1'b1;
                    tx_data_d  = src_chunk_type[int'(sel)*8 +: 8];
                end
            end
            SEND_TYPE: begin
                if (hs) begin
                    state_d   = SEND_SIZE;
                    tx_data_d = size_q;
                end
            end
            SEND_SIZE: begin
                if (hs) begin
                    if (size_q == 8'd0) begin
                        state_d         = ACK;
                        tx_valid_d      = 1'b0;
                        tx_data_d       = 8'd0;
                        done_d[grant_q] = 1'b1;
                    end else begin
                        state_d   = SEND_PAYLOAD;
                        cnt_d     = 8'd0;
                        tx_data_d = bytes_q[7:0];
                    end
                end
            end
            SEND_PAYLOAD: begin
                if (hs) begin
                    if (cnt_q == size_q - 8'd1) begin
                        state_d         = ACK;
                        tx_valid_d      = 1'b0;
                        tx_data_d       = 8'd0;
                        done_d[grant_q] = 1'b1;
                    end else begin
                        cnt_d     = nxt_cnt;
                        tx_data_d = bytes_q[int'(nxt_cnt)*8 +: 8];
                    end
                end
            end
            ACK: begin
                // Producer clears its request on this edge, so IDLE never sees a stale one.
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= IDLE;
            last_q     <= GRANT_W'(NUM_SOURCES - 1);
            grant_q    <= '0;
            type_q     <= '0;
            size_q     <= '0;
            bytes_q    <= '0;
            cnt_q      <= '0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
            done_q     <= '0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            grant_q    <= grant_d;
            type_q     <= type_d;
            size_q     <= size_d;
            bytes_q    <= bytes_d;
            cnt_q      <= cnt_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
            done_q     <= done_d;
        end
    end

    assign tx.tx_valid = tx_valid_q;
    assign tx.tx_data  = tx_data_q;
    assign src_done    = done_q;
    assign busy        = (state_q != IDLE);
    assign grant_id    = grant_q;

endmodule

// File: tb/tb_v_tx_arbiter.sv
// tb/tb_v_tx_arbiter.sv - scoreboard bench for v_tx_arbiter
module tb_v_tx_arbiter;
    localparam int NS = 4;
    localparam int P  = 32;

    typedef struct {
        int         src;
        logic [7:0] typ;
        int         sz;
    } frame_t;

    logic            CLK;
    logic            RST_N;
    logic [NS-1:0]   req;
    logic [NS*8-1:0] s_type;
    logic [NS*8-1:0] s_size;
    logic [NS*P*8-1:0] s_bytes;
    logic [NS-1:0]   src_done;
    logic            busy;
    logic [1:0]      grant_id;

    v_tx_arbiter_if tif();

    v_tx_arbiter #(
        .NUM_SOURCES(NS), .GRANT_W(2),
        .TEXT_BUFFER_BYTE_SIZE(P + 1), .TEXT_BUFFER_INDEX_SIZE(8)
    ) dut (
        .CLK(CLK), .RST_N(RST_N),
        .src_should_update(req),
        .src_chunk_type(s_type),
        .src_chunk_size(s_size),
        .src_chunk_bytes(s_bytes),
        .src_done(src_done),
        .tx(tif.master),
        .busy(busy),
        .grant_id(grant_id)
    );

    int total = 0;
    int bad   = 0;
    int ready_mode = 0;
    int pat = 0;
    int model_last = NS - 1;

    frame_t     exp_q[$];
    logic [7:0] exp_b[$];
    logic [7:0] got[$];

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Transmitter readiness: always, random, or the repeating 1,0,0 pattern.
    initial tif.tx_ready = 1'b1;
    always @(posedge CLK) begin
        #1;
        case (ready_mode)
            0: tif.tx_ready = 1'b1;
            1: tif.tx_ready = 1'($urandom % 2);
            default: begin
                tif.tx_ready = (pat == 0);
                pat = (pat + 1) % 3;
            end
        endcase
    end

    // Monitor: collects transfers, checks held data during stalls, and on each done
    // pulse compares the assembled frame with the oldest expected one.
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data  = 8'd0;
    frame_t     e;
    int         perr;
    logic [7:0] pb;
    always @(negedge CLK) begin
        if (!RST_N) begin
            got.delete();
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("hold_valid", 32'(tif.tx_valid), 32'd1);
                chk("hold_data", 32'(tif.tx_data), 32'(prev_data));
            end
            prev_stall = tif.tx_valid && !tif.tx_ready;
            prev_data  = tif.tx_data;
            if (tif.tx_valid && tif.tx_ready) got.push_back(tif.tx_data);
            if (src_done != '0) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_done: got %0b expected none", src_done);
                end else begin
                    e = exp_q.pop_front();
                    chk("done_mask", 32'(src_done), 32'(1 << e.src));
                    chk("grant_id", 32'(grant_id), 32'(e.src));
                    chk("ack_valid", 32'(tif.tx_valid), 32'd0);
                    chk("frame_len", 32'(got.size()), 32'(e.sz + 2));
                    if (got.size() >= 2) begin
                        chk("type_byte", 32'(got[0]), 32'(e.typ));
                        chk("size_byte", 32'(got[1]), 32'(e.sz));
                    end
                    perr = 0;
                    for (int i = 0; i < e.sz; i++) begin
                        pb = exp_b.pop_front();
                        if (i + 2 >= got.size() || got[i+2] !== pb) perr++;
                    end
                    chk("payload_errs", 32'(perr), 32'd0);
                end
                got.delete();
                req = req & ~src_done;
            end
        end
    end

    task automatic load_src(input int k, input int typ, input int sz);
        s_type[k*8 +: 8] = 8'(typ);
        s_size[k*8 +: 8] = 8'(sz);
        for (int i = 0; i < P; i++) s_bytes[(k*P+i)*8 +: 8] = 8'($urandom);
    endtask

    // Reference: among producers raised together, each grant goes to the first
    // still-pending producer after the previous winner; size is min(size, P).
    task automatic issue(input logic [NS-1:0] mask);
        logic [NS-1:0] pend;
        frame_t f;
        int c;
        pend = mask;
        while (pend != '0) begin
            c = (model_last + 1) % NS;
            while (!pend[c]) c = (c + 1) % NS;
            f.src = c;
            f.typ = s_type[c*8 +: 8];
            f.sz  = (int'(s_size[c*8 +: 8]) > P) ? P : int'(s_size[c*8 +: 8]);
            exp_q.push_back(f);
            for (int i = 0; i < f.sz; i++) exp_b.push_back(s_bytes[(c*P+i)*8 +: 8]);
            pend[c] = 1'b0;
            model_last = c;
        end
        req = req | mask;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 3000 && exp_q.size() != 0; i++) @(posedge CLK);
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL timeout: got %0d frames pending expected 0", exp_q.size());
            exp_q.delete();
            exp_b.delete();
            req = '0;
        end
        @(posedge CLK);
        #1;
    endtask

    initial begin
        logic [NS-1:0] m;
        RST_N = 1'b0;
        req = '0;
        s_type = '0;
        s_size = '0;
        s_bytes = '0;
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_valid", 32'(tif.tx_valid), 32'd0);
        chk("rst_data", 32'(tif.tx_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_grant", 32'(grant_id), 32'd0);
        chk("rst_done", 32'(src_done), 32'd0);
        RST_N = 1'b1;
        @(posedge CLK);
        #1;

        // Fairness: all four request together, expected order 0,1,2,3.
        for (int k = 0; k < NS; k++) load_src(k, 8'h10 + k, 1);
        issue(4'hF);
        wait_idle();

        // Exact timing of a 3-byte frame from producer 2.
        load_src(2, 5, 3);
        s_bytes[(2*P+0)*8 +: 8] = 8'h41;
        s_bytes[(2*P+1)*8 +: 8] = 8'h42;
        s_bytes[(2*P+2)*8 +: 8] = 8'h43;
        issue(4'b0100);
        @(negedge CLK);
        for (int c = 1; c <= 7; c++) begin
            @(negedge CLK);
            if (c <= 5) chk("t_valid", 32'(tif.tx_valid), 32'd1);
            case (c)
                1: chk("t_type", 32'(tif.tx_data), 32'h05);
                2: chk("t_size", 32'(tif.tx_data), 32'h03);
                3: chk("t_b0", 32'(tif.tx_data), 32'h41);
                4: chk("t_b1", 32'(tif.tx_data), 32'h42);
                5: chk("t_b2", 32'(tif.tx_data), 32'h43);
                6: chk("t_done", 32'(src_done), 32'b0100);
                default: begin
                    chk("t_busy", 32'(busy), 32'd0);
                    chk("t_done_clr", 32'(src_done), 32'd0);
                end
            endcase
        end
        wait_idle();

        // Stalls with ready pattern 1,0,0.
        ready_mode = 2;
        load_src(1, 8'hA1, 2);
        issue(4'b0010);
        wait_idle();

        // Empty payload, then an oversize chunk clamped to P, under random ready.
        ready_mode = 1;
        load_src(0, 8'h33, 0);
        issue(4'b0001);
        wait_idle();
        load_src(3, 8'h44, 40);
        issue(4'b1000);
        wait_idle();

        // Reset during payload byte 1; the same request is then resent in full.
        ready_mode = 0;
        load_src(1, 8'h77, 4);
        issue(4'b0010);
        repeat (4) @(posedge CLK);
        #1;
        chk("pre_rst_b1", 32'(tif.tx_data), 32'(s_bytes[(1*P+1)*8 +: 8]));
        RST_N = 1'b0;
        model_last = NS - 1;
        #1;
        chk("rst_mid_valid", 32'(tif.tx_valid), 32'd0);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_done", 32'(src_done), 32'd0);
        repeat (2) @(posedge CLK);
        #1;
        RST_N = 1'b1;
        wait_idle();

        // Source data changes after grant; snapshot must be sent.
        load_src(3, 8'h5C, 10);
        issue(4'b1000);
        repeat (2) @(posedge CLK);
        #1;
        load_src(3, 8'hEE, 20);
        wait_idle();

        // Randomised groups of simultaneous requests.
        for (int it = 0; it < 25; it++) begin
            ready_mode = int'($urandom_range(0, 1));
            m = 4'($urandom_range(1, 15));
            for (int k = 0; k < NS; k++)
                if (m[k]) load_src(k, int'($urandom % 256), int'($urandom_range(0, 40)));
            issue(m);
            wait_idle();
        end

        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/v_tx_arbiter.md
Name: v_tx_arbiter

Overview:
- Shares the single UART TX byte stream between NUM_SOURCES virtual-peripheral TX producers (text, leds, etc.).
- Each producer exposes should_update, chunk type, chunk size and chunk bytes, and expects a one-cycle reset/done pulse once its chunk has been sent.
- Arbitrates round-robin among requesting producers, snapshots the granted chunk, and serialises it as type byte, size byte, then payload bytes onto a valid/ready byte interface feeding the UART transmitter.
- Pulses the winning producer's done line when its chunk is complete.

Parameters:
- NUM_SOURCES, 4, number of producers; at least 1.
- GRANT_W, 2, width of grant index; must satisfy 2^GRANT_W >= NUM_SOURCES.
- TEXT_BUFFER_BYTE_SIZE, 33, buffer size in bytes; payload capacity P = TEXT_BUFFER_BYTE_SIZE-1 = 32 bytes.
- TEXT_BUFFER_INDEX_SIZE, 8, width of each size field; must be <= 8.

Ports:
- CLK  in  1  system clock; all logic on posedge.
- RST_N  in  1  asynchronous active-low reset.
- src_should_update  in  NUM_SOURCES  request per producer; bit k belongs to producer k.
- src_chunk_type  in  NUM_SOURCES*8  chunk type; slice k = [8k+7:8k].
- src_chunk_size  in  NUM_SOURCES*TEXT_BUFFER_INDEX_SIZE  payload byte count per producer.
- src_chunk_bytes  in  NUM_SOURCES*P*8  payload per producer; producer slice k, byte i = bits [(k*P+i)*8+7 : (k*P+i)*8].
- src_done  out  NUM_SOURCES  one-hot, one-cycle pulse to the granted producer's reset input.
- tx_data  out  8  byte to the UART transmitter.
- tx_valid  out  1  tx_data is valid.
- tx_ready  in  1  transmitter accepts the byte; a transfer happens on a posedge where tx_valid and tx_ready are both 1.
- busy  out  1  high in every state except IDLE.
- grant_id  out  GRANT_W  index of the current or most recent grant.

Behaviour:
- Reset (RST_N=0, asynchronous):
  - state=IDLE; src_done=0, tx_valid=0, tx_data=0, busy=0, grant_id=0.
  - Round-robin pointer last = NUM_SOURCES-1, so producer 0 has first priority.
  - Snapshot registers cleared.
- FSM states: IDLE, SEND_TYPE, SEND_SIZE, SEND_PAYLOAD, ACK.
- IDLE: if any src_should_update bit is set, on the same edge:
  - Select the first set bit scanning last+1, last+2, … modulo NUM_SOURCES.
  - grant_id<=sel; last<=sel.
  - Snapshot type, size and bytes of sel.
  - Set cnt=0; go to SEND_TYPE.
  - Requests arriving later do not affect an in-flight frame.
- Size clamp: snapshot size = min(src size, P). Zero-extend to 8 bits when TEXT_BUFFER_INDEX_SIZE < 8.
- SEND_TYPE: tx_valid=1, tx_data=type. On handshake go to SEND_SIZE.
- SEND_SIZE: tx_data=clamped size. On handshake:
  - size==0 goes to ACK.
  - Otherwise go to SEND_PAYLOAD.
- SEND_PAYLOAD: tx_data=payload byte cnt, byte 0 first. On handshake cnt++; when cnt reaches size-1 and a handshake occurs, go to ACK.
- Handshake rule: while tx_valid=1 and tx_ready=0, tx_data and state hold. tx_valid never drops mid-frame.
- tx_valid and tx_data are registered outputs.
- Latency with tx_ready tied to 1: request seen in IDLE at cycle 0 gives type byte valid at cycle 1. A frame of N payload bytes keeps tx_valid high for N+2 consecutive cycles.
- ACK: tx_valid=0; src_done[grant_id]=1 for exactly this one cycle; next state IDLE unconditionally.
  - The producer leaves its update state on this edge, so its request is low by the following IDLE cycle.
  - The arbiter never re-grants on a stale request.
- Back-to-back requests: minimum gap between frames is one ACK cycle plus one IDLE cycle.
- Fairness: with all producers requesting continuously, grants rotate 0,1,2,3,0…
- Simultaneous events:
  - A request dropped by a producer after grant does not abort the frame.
  - src_done still pulses for the granted producer.
- Reset mid-frame: frame is abandoned with no done pulse. The producer keeps requesting and is re-sent in full after RST_N deasserts (restarting from producer 0 priority).
- busy = (state != IDLE).

Test Plan:
- Reset, then src 2 requests type=5, size=3, bytes 0x41,0x42,0x43, tx_ready=1 -> tx stream 05 03 41 42 43 on cycles 1-5; src_done=4'b0100 on cycle 6 only; busy low on cycle 7.
- All 4 sources request continuously, size=1 each, and each source drops its request one cycle after its done pulse -> grant_id sequence 0,1,2,3; one src_done pulse per frame; no byte lost.
- tx_ready toggles 1,0,0,1,… during a size=2 frame -> tx_data is stable whenever tx_valid=1 and tx_ready=0; exactly 4 transfers occur in order type, size, b0, b1.
- Source requests with size=0 -> stream is type, 00, then a done pulse. Source requests with size=40 -> size byte 0x20 and 32 payload bytes.
- RST_N pulled low during payload byte 1 -> tx_valid and busy drop immediately with no src_done. After release the same request is retransmitted from the type byte.
- Source changes src_chunk_bytes mid-frame -> transmitted bytes equal the snapshot taken at grant.
